note_player: RTL and testbench
==============================

Name: note_player

Overview:
- One voice of the polyphonic synthesiser, directly downstream of song_reader.
- Accepts a note and duration on a load strobe and counts the duration down in beats.
- While counting, it runs a 20-bit phase accumulator at the sample strobe rate and produces a 16-bit signed triangle sample.
- Reports itself free through a level signal, which is what song_reader's note_X_done inputs consume.
- Three instances (one per voice) sit between song_reader and the mixer.

Parameters:
- PHASE_W, 20, phase accumulator width; step values are scaled to this width.
- SAMPLE_W, 16, output sample width, signed two's complement.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play_enable  in  1  high = run; low = freeze duration count and phase.
- note_to_load  in  6  note index: 0 = rest, 1..63 = semitones, 49 = A4 440 Hz.
- duration_to_load  in  6  length in beats; 0 = empty note.
- load_new_note  in  1  single-cycle strobe; latch note and duration.
- beat  in  1  single-cycle beat strobe from beat_generator.
- generate_next_sample  in  1  single-cycle 48 kHz sample strobe.
- done_with_note  out  1  level; high = voice free.
- new_sample_ready  out  1  single-cycle pulse; sample_out updated.
- sample_out  out  16  signed triangle sample.

Behaviour:
- Reset values: state IDLE, done_with_note=1, new_sample_ready=0, sample_out=0, phase=0, beat counter=0, step=0.
- States:
  - IDLE: done_with_note=1.
  - LOAD: one cycle; step lookup in flight.
  - PLAYING: done_with_note=0.
- Transitions:
  - IDLE + load_new_note with duration!=0 -> LOAD. Latch note and duration; phase clears to 0.
  - IDLE + load_new_note with duration==0 -> stay IDLE. done_with_note never drops.
  - LOAD -> PLAYING unconditionally. The registered step is valid from the first PLAYING cycle.
  - PLAYING + beat + play_enable: counter decrements. When the counter goes 1 -> 0, go to IDLE; done_with_note is high the next cycle.
  - PLAYING + load_new_note (retrigger): same as the IDLE load rules. A load with duration 0 goes to IDLE.
- Load priority: a load_new_note coincident with beat wins; that beat is not applied to the new note.
- Duration latency: done_with_note rises exactly N beats after the load when play_enable is held high.
- Sample path:
  - On generate_next_sample with state PLAYING and play_enable=1: phase <= phase + step, mod 2^20 (wrap silently).
  - Next cycle: new_sample_ready=1 for one cycle.
  - sample_out = (phase[19] ? ~phase[18:3] : phase[18:3]) - 16'h8000, computed from the updated phase.
- Rests: for note 0, step=0 and sample_out is forced to 0. The pulse still fires and the duration still counts.
- Other states: generate_next_sample in IDLE or LOAD gives no pulse and sample_out holds its last value.
- Same-cycle beat and sample: both are processed. The final-beat cycle still produces its sample pulse.
- play_enable low: beats and sample strobes are ignored, and state, phase and counter hold. Loads are still accepted.
- Reset mid-note returns to the reset values immediately; there is no partial pulse.

Decomposition:
- Shared package:
  - STEP table: 64 entries × 20 bits, step[n] = round(440·2^((n-49)/12)·2^20/48000) for n=1..63, step[0]=0.
  - State encodings IDLE, LOAD, PLAYING.
  - SAMPLE_RATE 48000.
- One sub-module, note_step_lut: a registered 64×20 ROM indexed by note with 1-cycle latency, reusing the song_rom coding style.

Test Plan:
- After reset, with no stimulus: done_with_note=1, sample_out=0, no new_sample_ready for 100 sample strobes.
- Load note 49 with duration 3, play_enable=1: done_with_note falls the cycle after the load. The first sample strobe gives phase 9612 (0x0258C) and sample_out = 0x04B1 - 0x8000 = 0x84B1. done_with_note rises on the cycle after the 3rd beat.
- Load note 0 with duration 2: pulses fire with sample_out=0 throughout; done_with_note rises after 2 beats.
- Load with duration 0: done_with_note stays 1 and no samples are generated.
- Drop play_enable after beat 1 of a 4-beat note and send 5 beats and 5 strobes: no pulses, phase and counter frozen. Re-enable: the note ends after 3 more beats.
- Retrigger mid-note with beat coincident to the load (note 61, duration 1): the beat is ignored and the phase restarts at 0. The note ends after 1 more beat; the 1st sample strobe gives phase 19224.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types and constants for one synthesiser voice: FSM states and the
// per-note phase step table for a 20-bit accumulator clocked at 48 kHz.
package note_player_pkg;

    localparam int unsigned SAMPLE_RATE = 48000;
    localparam int unsigned STEP_W      = 20;
    localparam int unsigned NOTE_W      = 6;
    localparam int unsigned NUM_NOTES   = 64;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlaying
    } state_e;

    // step[n] = round(440 * 2^((n-49)/12) * 2^20 / SAMPLE_RATE), note 0 is a rest
    localparam logic [STEP_W-1:0] STEP_TABLE [NUM_NOTES] = '{
        20'd0,
        20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,
        20'd850,   20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,
        20'd1201,  20'd1273,  20'd1349,  20'd1429,  20'd1514,  20'd1604,
        20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,  20'd2268,
        20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
        20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
        20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
        20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
        20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
        20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
        20'd19224, 20'd20367, 20'd21578
    };

endpackage

// File: rtl/note_player_step_lut.sv
// Registered note-to-phase-step ROM; data appears one cycle after the address.
module note_step_lut
    import note_player_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NOTE_W-1:0] note_i,
    output logic [STEP_W-1:0] step_o
);

    logic [STEP_W-1:0] step_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_q <= '0;
        end else begin
            step_q <= STEP_TABLE[note_i];
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/note_player.sv
// One synthesiser voice: counts a note down in beats and emits a triangle
// sample from a phase accumulator on each sample strobe while playing.
module note_player
    import note_player_pkg::*;
#(
    parameter int unsigned PHASE_W  = 20,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                play_enable_i,
    input  logic [NOTE_W-1:0]   note_to_load_i,
    input  logic [5:0]          duration_to_load_i,
    input  logic                load_new_note_i,
    input  logic                beat_i,
    input  logic                generate_next_sample_i,
    output logic                done_with_note_o,
    output logic                new_sample_ready_o,
    output logic [SAMPLE_W-1:0] sample_out_o
);

    localparam logic [SAMPLE_W-1:0] MidScale = {1'b1, {(SAMPLE_W-1){1'b0}}};

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [5:0]          count_q, count_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                ready_q, ready_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    logic [STEP_W-1:0]   step;
    logic                accept;
    logic                advance;
    logic                last_beat;
    logic [PHASE_W-1:0]  phase_next;
    logic [SAMPLE_W-1:0] fold;

    note_step_lut u_step_lut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .note_i  (note_q),
        .step_o  (step)
    );

    // A load wins over any beat or sample strobe in the same cycle; loads are
    // ignored only during the single LOAD cycle while the step fetch is in flight.
    assign accept    = load_new_note_i && (state_q != StLoad);
    assign advance   = (state_q == StPlaying) && play_enable_i && !accept;
    assign last_beat = advance && beat_i && (count_q == 6'd1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (duration_to_load_i != '0)) state_d = StLoad;
            end
            StLoad: begin
                state_d = StPlaying;
            end
            StPlaying: begin
                if (accept) begin
                    state_d = (duration_to_load_i != '0) ? StLoad : StIdle;
                end else if (last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done_with_note_o   = (state_q == StIdle);
        new_sample_ready_o = ready_q;
        sample_out_o       = sample_q;
    end

    always_comb begin
        phase_next = phase_q + PHASE_W'(step);
        // Fold the upper half of the cycle back down to form the triangle.
        fold = phase_next[PHASE_W-1] ? ~phase_next[PHASE_W-2 -: SAMPLE_W]
                                     :  phase_next[PHASE_W-2 -: SAMPLE_W];

        note_d   = note_q;
        count_d  = count_q;
        phase_d  = phase_q;
        ready_d  = 1'b0;
        sample_d = sample_q;

        if (accept) begin
            if (duration_to_load_i != '0) begin
                note_d  = note_to_load_i;
                count_d = duration_to_load_i;
            end else begin
                count_d = '0;
            end
            phase_d = '0;
        end else if (advance) begin
            if (beat_i) count_d = count_q - 6'd1;
            if (generate_next_sample_i) begin
                phase_d  = phase_next;
                ready_d  = 1'b1;
                sample_d = (note_q == '0) ? '0 : (fold - MidScale);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            note_q   <= '0;
            count_q  <= '0;
            phase_q  <= '0;
            ready_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            note_q   <= note_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            ready_q  <= ready_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player against a beat/phase reference model.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        beat;
    logic        generate_next_sample;
    logic        done_with_note;
    logic        new_sample_ready;
    logic [15:0] sample_out;

    int tests = 0;
    int fails = 0;

    // Reference model: beats remaining, one-cycle settle after a load, phase.
    int m_beats_left;
    bit m_settle;
    int m_note;
    int m_phase;
    bit m_ready;
    int m_sample;

    note_player u_dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .play_enable_i          (play_enable),
        .note_to_load_i         (note_to_load),
        .duration_to_load_i     (duration_to_load),
        .load_new_note_i        (load_new_note),
        .beat_i                 (beat),
        .generate_next_sample_i (generate_next_sample),
        .done_with_note_o       (done_with_note),
        .new_sample_ready_o     (new_sample_ready),
        .sample_out_o           (sample_out)
    );

    always #5 clk = ~clk;

    function automatic int step_of(input int n);
        real r;
        if (n == 0) return 0;
        r = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 1048576.0 / 48000.0;
        return $rtoi(r + 0.5);
    endfunction

    function automatic int tri_of(input int p);
        int v;
        v = (p < 524288) ? (p >>> 3) : (131071 - (p >>> 3));
        return (v + 32768) % 65536;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_beats_left = 0;
        m_settle     = 0;
        m_note       = 0;
        m_phase      = 0;
        m_ready      = 0;
        m_sample     = 0;
    endtask

    task automatic model_step(input bit ld, input int n, input int d, input bit bt,
                              input bit gn, input bit en);
        m_ready = 0;
        if (ld && !m_settle) begin
            if (d != 0) begin
                m_note       = n;
                m_beats_left = d;
                m_settle     = 1;
            end else begin
                m_beats_left = 0;
            end
            m_phase = 0;
        end else if (m_settle) begin
            m_settle = 0;
        end else if (m_beats_left > 0 && en) begin
            if (gn) begin
                m_phase  = (m_phase + step_of(m_note)) % 1048576;
                m_ready  = 1;
                m_sample = (m_note == 0) ? 0 : tri_of(m_phase);
            end
            if (bt) m_beats_left--;
        end
    endtask

    task automatic check_outputs();
        check("done", 32'(done_with_note), 32'(m_beats_left == 0));
        check("ready", 32'(new_sample_ready), 32'(m_ready));
        check("sample", 32'(sample_out), 32'(m_sample));
    endtask

    // One clock: drive after the falling edge, compare after the next falling edge.
    task automatic cyc(input bit ld, input int n, input int d, input bit bt,
                       input bit gn, input bit en);
        load_new_note        = ld;
        note_to_load         = 6'(n);
        duration_to_load     = 6'(d);
        beat                 = bt;
        generate_next_sample = gn;
        play_enable          = en;
        model_step(ld, n, d, bt, gn, en);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        load_new_note        = 1'b0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        play_enable          = 1'b1;
        note_to_load         = '0;
        duration_to_load     = '0;
        load_new_note        = 1'b0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Idle voice ignores sample strobes.
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 1, 1);

        // A4 for three beats.
        cyc(1, 49, 3, 0, 0, 1);
        check("a4_busy", 32'(done_with_note), 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        check("a4_first", 32'(sample_out), 32'h84B1);
        for (int b = 0; b < 3; b++) begin
            cyc(0, 0, 0, 0, 1, 1);
            cyc(0, 0, 0, 1, 1, 1);
        end
        check("a4_done", 32'(done_with_note), 32'd1);

        // Rest for two beats: pulses with zero samples.
        cyc(1, 0, 2, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int b = 0; b < 2; b++) begin
            cyc(0, 0, 0, 0, 1, 1);
            cyc(0, 0, 0, 1, 1, 1);
        end

        // Empty note.
        cyc(1, 30, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1);

        // Freeze after one beat of a four-beat note.
        cyc(1, 30, 4, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        check("freeze_busy", 32'(done_with_note), 32'd0);
        cyc(0, 0, 0, 1, 1, 1);
        check("freeze_done", 32'(done_with_note), 32'd1);

        // Retrigger with a coincident beat.
        cyc(1, 40, 5, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(1, 61, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        check("retrig_first", 32'(sample_out), 32'h8963);
        check("retrig_busy", 32'(done_with_note), 32'd0);
        cyc(0, 0, 0, 1, 0, 1);
        check("retrig_done", 32'(done_with_note), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 59) == 0, int'($urandom_range(0, 63)),
                int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0);
        end

        // Reset in the middle of a note, between clock edges.
        cyc(1, 20, 5, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        generate_next_sample = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        generate_next_sample = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
